// File: rtl/wb_pkg.sv
// Shared widths and the pending-write entry type for the writeback buffer.
package wb_pkg;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Pending-write storage: two pushes and one pop per cycle, all entries exposed for snooping.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         clr,
   input  wb_entry_t                    i_push0,
   input  wb_entry_t                    i_push1,
   input  logic                         i_pop,
   output wb_entry_t                    o_head,
   output logic [$clog2(DEPTH)-1:0]     o_rd_ptr,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [$clog2(DEPTH+1)-1:0]   o_count_nxt,
   output wb_entry_t                    o_entries [DEPTH]
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic [1:0]       w_n_push;
   logic [PTR_W-1:0] w_wr_ptr1;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_n_push    = {1'b0, i_push0.valid} + {1'b0, i_push1.valid};
   assign w_wr_ptr1   = i_push0.valid ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
   assign w_count_nxt = r_count + CNT_W'(w_n_push) - CNT_W'(i_pop);

   // Pop clears first so a same-edge push into the freed slot (full case) wins.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_pop) begin
            r_mem[r_rd_ptr].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
         end
         if (i_push0.valid) r_mem[r_wr_ptr]  <= i_push0;
         if (i_push1.valid) r_mem[w_wr_ptr1] <= i_push1;
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
         r_count  <= w_count_nxt;
      end
   end

   assign o_head      = r_mem[r_rd_ptr];
   assign o_rd_ptr    = r_rd_ptr;
   assign o_count     = r_count;
   assign o_count_nxt = w_count_nxt;
   assign o_entries   = r_mem;
endmodule

// File: rtl/wb_write_buffer.sv
// Merges ALU and load writebacks into one register-file write port, with snoop forwarding.
module wb_write_buffer
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              stall,
   output logic [ADDR_W-1:0] Caddr,
   output logic [DATA_W-1:0] C,
   output logic              load,
   input  logic [ADDR_W-1:0] Aaddr,
   input  logic [ADDR_W-1:0] Baddr,
   output logic              A_hit,
   output logic              B_hit,
   output logic [DATA_W-1:0] A_fwd,
   output logic [DATA_W-1:0] B_fwd
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic              r_stall;
   logic              r_load;
   logic [ADDR_W-1:0] r_caddr;
   logic [DATA_W-1:0] r_c;

   wb_entry_t         w_push0;
   wb_entry_t         w_push1;
   wb_entry_t         w_head;
   wb_entry_t         w_entries [DEPTH];
   logic [PTR_W-1:0]  w_rd_ptr;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_pop;
   logic [PTR_W-1:0]  w_idx;

   // r0 writes are discarded at acceptance; ALU is the older entry on dual issue.
   assign w_push0 = '{valid: alu_valid && !r_stall && (alu_addr != '0), addr: alu_addr, data: alu_data};
   assign w_push1 = '{valid: mem_valid && !r_stall && (mem_addr != '0), addr: mem_addr, data: mem_data};
   assign w_pop   = (w_count != '0);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .clr         (clr),
      .i_push0     (w_push0),
      .i_push1     (w_push1),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_rd_ptr    (w_rd_ptr),
      .o_count     (w_count),
      .o_count_nxt (w_count_nxt),
      .o_entries   (w_entries)
   );

   // Output register; stall guarantees room for a full dual issue on the next edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_stall <= 1'b0;
         r_load  <= 1'b0;
         r_caddr <= '0;
         r_c     <= '0;
      end else begin
         r_stall <= (32'(w_count_nxt) + 32'd2) > DEPTH;
         r_load  <= w_pop;
         if (w_pop) begin
            r_caddr <= w_head.addr;
            r_c     <= w_head.data;
         end
      end
   end

   assign stall = r_stall;
   assign load  = r_load;
   assign Caddr = r_caddr;
   assign C     = r_c;

   // Scan oldest to youngest so the youngest match overrides; output register is oldest of all.
   always_comb begin
      A_hit = 1'b0;
      A_fwd = '0;
      B_hit = 1'b0;
      B_fwd = '0;
      w_idx = '0;
      if (r_load && (Aaddr != '0) && (r_caddr == Aaddr)) begin
         A_hit = 1'b1;
         A_fwd = r_c;
      end
      if (r_load && (Baddr != '0) && (r_caddr == Baddr)) begin
         B_hit = 1'b1;
         B_fwd = r_c;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = w_rd_ptr + PTR_W'(i);
         if (w_entries[w_idx].valid && (Aaddr != '0) && (w_entries[w_idx].addr == Aaddr)) begin
            A_hit = 1'b1;
            A_fwd = w_entries[w_idx].data;
         end
         if (w_entries[w_idx].valid && (Baddr != '0) && (w_entries[w_idx].addr == Baddr)) begin
            B_hit = 1'b1;
            B_fwd = w_entries[w_idx].data;
         end
      end
   end
endmodule
